// File: rtl/window_accumulator_pkg.sv
// Shared types and defaults for the window accumulator and its neighbours.
// Stage encodings and radius codes are common with the broadcast stage.
package window_accumulator_pkg;

  localparam int DATA_W  = 18;
  localparam int ACC_W   = 40;
  localparam int COORD_W = 8;
  localparam int WADDR_W = 16;

  localparam logic [1:0] RADIUS_1x1 = 2'd0;
  localparam logic [1:0] RADIUS_3x3 = 2'd1;
  localparam logic [1:0] RADIUS_5x5 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_t;

  // The reserved radius code behaves like the largest window.
  function automatic logic [1:0] clamp_radius(input logic [1:0] r);
    return (r == 2'd3) ? RADIUS_5x5 : r;
  endfunction

endpackage

// File: rtl/window_hit_calc.sv
// Combinational window membership test with window-relative offsets.
// Compares in COORD_W+1 bits so edges at 0 and the top coordinate never wrap.
module window_hit_calc #(
  parameter int COORD_W = 8
) (
  input  logic               pix_en,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [1:0]         r,
  output logic               hit,
  output logic [2:0]         dx,
  output logic [2:0]         dy,
  output logic               last
);

  logic [COORD_W:0] px;
  logic [COORD_W:0] py;
  logic [COORD_W:0] x0;
  logic [COORD_W:0] y0;
  logic [COORD_W:0] rr;
  logic             in_x;
  logic             in_y;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};
  assign x0 = {1'b0, cx};
  assign y0 = {1'b0, cy};
  assign rr = {{(COORD_W-1){1'b0}}, r};

  assign in_x = (px + rr >= x0) && (px <= x0 + rr);
  assign in_y = (py + rr >= y0) && (py <= y0 + rr);
  assign hit  = pix_en && in_x && in_y;

  // Offsets are at most 2r = 4, so the low three bits carry the full value.
  assign dx = pix_x[2:0] - cx[2:0] + {1'b0, r};
  assign dy = pix_y[2:0] - cy[2:0] + {1'b0, r};

  assign last = hit && (dx == {r, 1'b0}) && (dy == {r, 1'b0});

endmodule

// File: rtl/window_accumulator.sv
// Per-output-pixel consumer: snoops the broadcast stream, weights window
// pixels and accumulates one signed dot product per round.
module window_accumulator #(
  parameter int DATA_W  = window_accumulator_pkg::DATA_W,
  parameter int ACC_W   = window_accumulator_pkg::ACC_W,
  parameter int COORD_W = window_accumulator_pkg::COORD_W,
  parameter int WADDR_W = window_accumulator_pkg::WADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] center_x,
  input  logic [COORD_W-1:0] center_y,
  input  logic [1:0]         radius,
  input  logic               pix_en,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [DATA_W-1:0]  pix_data,
  input  logic               round,
  output logic [WADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0]  weight_data,
  output logic               busy,
  output logic [ACC_W-1:0]   result,
  output logic               result_valid
);

  import window_accumulator_pkg::*;

  acc_state_t state;
  acc_state_t state_n;

  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic [1:0]         r;
  logic [2:0]         k;
  logic [4:0]         kk;
  logic [WADDR_W-1:0] z;
  logic [WADDR_W-1:0] addr_n;

  logic       accepting;
  logic       hit;
  logic       last;
  logic [2:0] dx;
  logic [2:0] dy;

  logic v1;
  logic v2;
  logic signed [DATA_W-1:0]   pix_q1;
  logic signed [DATA_W-1:0]   pix_q2;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    acc;
  logic        [ACC_W-1:0]    product_ext;

  assign accepting = pix_en && (state == ST_ACCUM);

  window_hit_calc #(
    .COORD_W (COORD_W)
  ) u_hit (
    .pix_en (accepting),
    .pix_x  (pix_x),
    .pix_y  (pix_y),
    .cx     (cx),
    .cy     (cy),
    .r      (r),
    .hit    (hit),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  assign k  = {r, 1'b1};
  assign kk = {2'b00, k} * {2'b00, k};

  assign addr_n = z * {{(WADDR_W-5){1'b0}}, kk}
                + {{(WADDR_W-3){1'b0}}, dy} * {{(WADDR_W-3){1'b0}}, k}
                + {{(WADDR_W-3){1'b0}}, dx};

  assign product = pix_q2 * $signed(weight_data);
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (start) state_n = ST_ACCUM;
      ST_ACCUM: if (round) state_n = ST_DRAIN;
      ST_DRAIN: if (!v1 && !v2) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cx          <= '0;
      cy          <= '0;
      r           <= '0;
      z           <= '0;
      weight_addr <= '0;
      pix_q1      <= '0;
      pix_q2      <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      acc         <= '0;
      result      <= '0;
    end else begin
      state  <= state_n;
      v1     <= hit;
      v2     <= v1;
      pix_q2 <= pix_q1;
      if (start && state == ST_IDLE) begin
        cx  <= center_x;
        cy  <= center_y;
        r   <= clamp_radius(radius);
        z   <= '0;
        acc <= '0;
      end
      // Plane index moves on together with the address of the plane's last tap.
      if (hit) begin
        weight_addr <= addr_n;
        pix_q1      <= $signed(pix_data);
        if (last) z <= z + 1'b1;
      end
      if (v2) acc <= acc + $signed(product_ext);
      if (state == ST_DRAIN && state_n == ST_DONE) result <= acc;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_window_accumulator.sv
// Directed and randomized checks of window_accumulator against a
// coordinate-level reference model of the window dot product.
module tb_window_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  center_x;
  logic [7:0]  center_y;
  logic [1:0]  radius;
  logic        pix_en;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [17:0] pix_data;
  logic        round;
  logic [15:0] weight_addr;
  logic [17:0] weight_data;
  logic        busy;
  logic [39:0] result;
  logic        result_valid;

  logic [17:0] wmem [0:1023];

  int checks = 0;
  int failures = 0;

  int     m_cx;
  int     m_cy;
  int     m_r;
  int     m_z;
  longint m_acc;

  window_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .center_x     (center_x),
    .center_y     (center_y),
    .radius       (radius),
    .pix_en       (pix_en),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .round        (round),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) weight_data <= wmem[weight_addr[9:0]];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 1024; i++) wmem[i] = 18'(v);
  endtask

  function automatic bit m_hit(input int x, input int y);
    return (x >= m_cx - m_r) && (x <= m_cx + m_r) &&
           (y >= m_cy - m_r) && (y <= m_cy + m_r);
  endfunction

  function automatic int rand_data();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic send_pix(input int x, input int y, input int d,
                          input bit en, input bit rnd);
    bit hit;
    int dx;
    int dy;
    int k;
    int addr;
    logic signed [17:0] ws;
    pix_en = en;
    pix_x = 8'(x);
    pix_y = 8'(y);
    pix_data = 18'(d);
    round = rnd;
    hit = en && m_hit(x, y);
    addr = 0;
    if (hit) begin
      dx = x - m_cx + m_r;
      dy = y - m_cy + m_r;
      k = 2 * m_r + 1;
      addr = m_z * k * k + dy * k + dx;
      ws = wmem[addr];
      m_acc += longint'(d) * longint'(ws);
      if (dx == 2 * m_r && dy == 2 * m_r) m_z++;
    end
    @(posedge clk);
    #1;
    if (hit) check("weight_addr", 64'(weight_addr), 64'(addr));
    pix_en = 1'b0;
    round = 1'b0;
  endtask

  task automatic start_win(input int cx, input int cy, input int rad);
    start = 1'b1;
    center_x = 8'(cx);
    center_y = 8'(cy);
    radius = 2'(rad);
    @(posedge clk);
    #1;
    start = 1'b0;
    m_cx = cx;
    m_cy = cy;
    m_r = (rad == 3) ? 2 : rad;
    m_z = 0;
    m_acc = 0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic raster(input int lo, input int hi, input int d,
                        input bit rand_d, input bit gaps);
    for (int y = lo; y <= hi; y++)
      for (int x = lo; x <= hi; x++) begin
        if (gaps && $urandom_range(0, 3) == 0)
          send_pix(int'($urandom_range(lo, hi)), int'($urandom_range(lo, hi)),
                   rand_data(), 1'b0, 1'b0);
        send_pix(x, y, rand_d ? rand_data() : d, 1'b1, 1'b0);
      end
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    logic [39:0] expv;
    logic [63:0] wide;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      wide = 64'(m_acc);
      expv = wide[39:0];
      check({tag, "_result"}, 64'(result), 64'(expv));
      if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      @(posedge clk);
      #1;
      check({tag, "_valid_pulse"}, 64'(result_valid), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_held"}, 64'(result), 64'(expv));
    end
  endtask

  initial begin
    logic [15:0] addr_before;
    int rad;
    int re;
    int cx;
    int cy;
    int planes;
    int coords [6];

    rst = 1'b1;
    start = 1'b0;
    center_x = '0;
    center_y = '0;
    radius = '0;
    pix_en = 1'b0;
    pix_x = '0;
    pix_y = '0;
    pix_data = '0;
    round = 1'b0;
    fill_const(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_addr", 64'(weight_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 3x3 window, unit data and weights
    fill_const(1);
    start_win(5, 5, 1);
    raster(0, 9, 1, 1'b0, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t1", 0);

    // three planes with ramp weights
    for (int i = 0; i < 1024; i++) wmem[i] = 18'(i);
    start_win(5, 5, 1);
    for (int p = 0; p < 3; p++) raster(0, 9, 1, 1'b0, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t2", 0);
    check("t2_z_end", 64'(dut.z), 64'd3);

    // 5x5 window in the corner, negative data
    fill_const(2);
    start_win(2, 2, 2);
    raster(0, 9, -3, 1'b0, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t3", 0);

    // only pixels outside the window
    addr_before = weight_addr;
    start_win(5, 5, 1);
    send_pix(9, 9, 5, 1'b1, 1'b0);
    send_pix(0, 0, 5, 1'b1, 1'b0);
    send_pix(9, 0, 5, 1'b1, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t4", 1);
    check("t4_no_reads", 64'(weight_addr), 64'(addr_before));

    // final hit in the same cycle as round
    for (int i = 0; i < 1024; i++) wmem[i] = 18'($urandom);
    start_win(5, 5, 1);
    for (int y = 4; y <= 6; y++)
      for (int x = 4; x <= 6; x++)
        send_pix(x, y, rand_data(), 1'b1, (x == 6 && y == 6));
    wait_result("t5", 3);

    // reset mid-accumulation, then a fresh window with an ignored start
    fill_const(1);
    start_win(5, 5, 1);
    for (int x = 4; x <= 6; x++) send_pix(x, 4, 7, 1'b1, 1'b0);
    send_pix(4, 5, 7, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_result", 64'(result), 64'd0);
    check("t6_rst_z", 64'(dut.z), 64'd0);
    start_win(5, 5, 1);
    send_pix(0, 0, 0, 1'b0, 1'b0);
    start = 1'b1;
    center_x = 8'd2;
    center_y = 8'd2;
    radius = 2'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t6_busy_kept", 64'(busy), 64'd1);
    raster(0, 9, 1, 1'b0, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t6", 0);

    // window at the top of coordinate space: no wrap to 0
    for (int i = 0; i < 1024; i++) wmem[i] = 18'($urandom);
    coords = '{252, 253, 254, 255, 0, 1};
    start_win(254, 254, 1);
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 6; i++)
        send_pix(coords[i], coords[j], rand_data(), 1'b1, 1'b0);
    send_pix(0, 0, 0, 1'b0, 1'b1);
    wait_result("t7", 0);

    // randomized windows, planes, data and blocked cycles
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 1024; i++) wmem[i] = 18'($urandom);
      rad = int'($urandom_range(0, 3));
      re = (rad == 3) ? 2 : rad;
      cx = int'($urandom_range(0, 11 - re));
      cy = int'($urandom_range(0, 11 - re));
      planes = int'($urandom_range(1, 3));
      start_win(cx, cy, rad);
      for (int p = 0; p < planes; p++) raster(0, 11, 0, 1'b1, 1'b1);
      send_pix(0, 0, 0, 1'b0, 1'b1);
      wait_result("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
